// File: rtl/yutorina_spr.sv
// yutorina_spr_ctrl: shares the SPR port between EX stage and debug unit,
// and sequences tear-free H/L/H reads of the 64-bit cycle counter.
module yutorina_spr_ctrl #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32,
  parameter logic [ADDR_W-1:0] CNT_L_ADDR = 'h01,
  parameter logic [ADDR_W-1:0] CNT_H_ADDR = 'h02,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_wr,
  input  logic [DATA_W-1:0] cpu_w_data,
  output logic [DATA_W-1:0] cpu_r_data,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic              dbg_wr,
  input  logic [DATA_W-1:0] dbg_w_data,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] dbg_r_data,
  output logic [ADDR_W-1:0] spr_addr,
  output logic              spr_wr,
  output logic [DATA_W-1:0] spr_w_data,
  input  logic [DATA_W-1:0] spr_r_data
);

  typedef enum logic [2:0] {
    IDLE, RD_H0, RD_L, RD_H1, DACK
  } state_t;

  localparam logic [3:0] SMAX = 4'(STARVE_MAX);

  state_t state, state_n;
  logic own, own_n;
  logic [3:0] starve_cnt, starve_n;
  logic [1:0] shvalid, shvalid_n;
  logic [1:0][DATA_W-1:0] shadow, shadow_n;
  logic [DATA_W-1:0] h0, h0_n;
  logic [DATA_W-1:0] lo, lo_n;
  logic dbg_ack_n;
  logic [DATA_W-1:0] dbg_r_data_n;

  logic dbg_win;
  logic [ADDR_W-1:0] m_addr;
  logic m_wr;
  logic [DATA_W-1:0] m_wd;
  logic done;
  logic [DATA_W-1:0] rd;
  logic cpu_done;

  assign dbg_win = dbg_req & (~cpu_req | (starve_cnt == SMAX));
  assign m_addr = dbg_win ? dbg_addr : cpu_addr;
  assign m_wr = dbg_win ? dbg_wr : cpu_wr;
  assign m_wd = dbg_win ? dbg_w_data : cpu_w_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      own <= 1'b0;
      starve_cnt <= '0;
      shvalid <= '0;
      shadow <= '0;
      h0 <= '0;
      lo <= '0;
      dbg_ack <= 1'b0;
      dbg_r_data <= '0;
    end else begin
      state <= state_n;
      own <= own_n;
      starve_cnt <= starve_n;
      shvalid <= shvalid_n;
      shadow <= shadow_n;
      h0 <= h0_n;
      lo <= lo_n;
      dbg_ack <= dbg_ack_n;
      dbg_r_data <= dbg_r_data_n;
    end
  end

  always_comb begin
    state_n = state;
    own_n = own;
    starve_n = starve_cnt;
    shvalid_n = shvalid;
    shadow_n = shadow;
    h0_n = h0;
    lo_n = lo;
    dbg_ack_n = 1'b0;
    dbg_r_data_n = dbg_r_data;
    spr_addr = '0;
    spr_wr = 1'b0;
    spr_w_data = '0;
    cpu_r_data = '0;
    cpu_done = 1'b0;
    done = 1'b0;
    rd = '0;
    unique case (state)
      IDLE: begin
        if (dbg_req & cpu_req & ~dbg_win)
          starve_n = (starve_cnt == SMAX) ? SMAX : starve_cnt + 4'd1;
        else
          starve_n = '0;
        if (cpu_req | dbg_req) begin
          own_n = dbg_win;
          // The grant cycle doubles as the first H read
          if (~m_wr & (m_addr == CNT_L_ADDR)) begin
            spr_addr = CNT_H_ADDR;
            h0_n = spr_r_data;
            state_n = RD_L;
          end else if (~m_wr & (m_addr == CNT_H_ADDR) & shvalid[dbg_win]) begin
            shvalid_n[dbg_win] = 1'b0;
            rd = shadow[dbg_win];
            done = 1'b1;
          end else begin
            spr_addr = m_addr;
            spr_wr = m_wr;
            spr_w_data = m_wd;
            rd = spr_r_data;
            if (m_wr)
              shvalid_n[dbg_win] = 1'b0;
            done = 1'b1;
          end
          if (done) begin
            if (dbg_win) begin
              dbg_r_data_n = rd;
              dbg_ack_n = 1'b1;
              state_n = DACK;
            end else begin
              cpu_done = 1'b1;
              cpu_r_data = rd;
            end
          end
        end
      end
      RD_H0: begin
        spr_addr = CNT_H_ADDR;
        h0_n = spr_r_data;
        state_n = RD_L;
      end
      RD_L: begin
        spr_addr = CNT_L_ADDR;
        lo_n = spr_r_data;
        state_n = RD_H1;
      end
      RD_H1: begin
        spr_addr = CNT_H_ADDR;
        if (spr_r_data == h0) begin
          shadow_n[own] = h0;
          shvalid_n[own] = 1'b1;
          if (own) begin
            dbg_r_data_n = lo;
            dbg_ack_n = 1'b1;
            state_n = DACK;
          end else begin
            cpu_done = 1'b1;
            cpu_r_data = lo;
            state_n = IDLE;
          end
        end else begin
          h0_n = spr_r_data;
          state_n = RD_L;
        end
      end
      DACK: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign cpu_stall = cpu_req & ~cpu_done;

endmodule

// File: tb/tb_yutorina_spr_ctrl.sv
// Directed bench for yutorina_spr_ctrl with a behavioural SPR file
// and counter; expected read data flows through per-requester queues.
module tb_yutorina_spr_ctrl;

  logic clk;
  logic rst;
  logic cpu_req;
  logic [4:0] cpu_addr;
  logic cpu_wr;
  logic [31:0] cpu_w_data;
  logic [31:0] cpu_r_data;
  logic cpu_stall;
  logic dbg_req;
  logic [4:0] dbg_addr;
  logic dbg_wr;
  logic [31:0] dbg_w_data;
  logic dbg_ack;
  logic [31:0] dbg_r_data;
  logic [4:0] spr_addr;
  logic spr_wr;
  logic [31:0] spr_w_data;
  logic [31:0] spr_r_data;

  logic [31:0] regs [32];
  logic [63:0] cnt;
  logic cnt_en;
  logic cnt_ld;
  logic [63:0] cnt_val;

  logic [31:0] cq [$];
  logic [31:0] dq [$];
  int n_tests;
  int n_fail;

  yutorina_spr_ctrl dut (
    .clk(clk),
    .rst(rst),
    .cpu_req(cpu_req),
    .cpu_addr(cpu_addr),
    .cpu_wr(cpu_wr),
    .cpu_w_data(cpu_w_data),
    .cpu_r_data(cpu_r_data),
    .cpu_stall(cpu_stall),
    .dbg_req(dbg_req),
    .dbg_addr(dbg_addr),
    .dbg_wr(dbg_wr),
    .dbg_w_data(dbg_w_data),
    .dbg_ack(dbg_ack),
    .dbg_r_data(dbg_r_data),
    .spr_addr(spr_addr),
    .spr_wr(spr_wr),
    .spr_w_data(spr_w_data),
    .spr_r_data(spr_r_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (cnt_ld)
      cnt <= cnt_val;
    else if (cnt_en)
      cnt <= cnt + 64'd1;
    if (!rst) begin
      for (int i = 0; i < 32; i++)
        regs[i] <= 32'h0;
    end else if (spr_wr) begin
      regs[spr_addr] <= spr_w_data;
    end
  end

  assign spr_r_data = (spr_addr == 5'h01) ? cnt[31:0] :
                      (spr_addr == 5'h02) ? cnt[63:32] :
                      regs[spr_addr];

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_cnt(input logic [63:0] v, input logic en);
    cnt_en = en;
    cnt_val = v;
    cnt_ld = 1'b1;
    @(posedge clk);
    #1 cnt_ld = 1'b0;
  endtask

  task automatic cpu_op(input logic [4:0] a, input logic w,
                        input logic [31:0] d, input logic [31:0] exp,
                        input int est, input logic [4:0] esa,
                        input bit chkd);
    int st;
    bit fin;
    logic [31:0] e;
    cq.push_back(exp);
    @(posedge clk);
    #1;
    cpu_req = 1'b1;
    cpu_addr = a;
    cpu_wr = w;
    cpu_w_data = d;
    st = 0;
    fin = 0;
    for (int i = 0; i < 16 && !fin; i++) begin
      @(negedge clk);
      if (!cpu_stall) fin = 1;
      else st++;
    end
    chk("cpu_complete", 64'(fin), 64'd1);
    e = cq.pop_front();
    if (fin) begin
      chk("cpu_stalls", 64'(st), 64'(est));
      chk("cpu_spr_addr", 64'(spr_addr), 64'(esa));
      chk("cpu_spr_wr", 64'(spr_wr), 64'(w));
      if (w) chk("cpu_spr_w_data", 64'(spr_w_data), 64'(d));
      if (chkd) chk("cpu_r_data", 64'(cpu_r_data), 64'(e));
    end
    @(posedge clk);
    #1;
    cpu_req = 1'b0;
    cpu_wr = 1'b0;
    cpu_addr = '0;
    cpu_w_data = '0;
  endtask

  task automatic dbg_op(input logic [4:0] a, input logic w,
                        input logic [31:0] d, input logic [31:0] exp,
                        input int elat, input logic [4:0] esa,
                        input bit chkd);
    int lat;
    logic [31:0] e;
    dq.push_back(exp);
    @(posedge clk);
    #1;
    dbg_req = 1'b1;
    dbg_addr = a;
    dbg_wr = w;
    dbg_w_data = d;
    @(negedge clk);
    chk("dbg_grant_addr", 64'(spr_addr), 64'(esa));
    lat = -1;
    for (int k = 1; k < 12 && lat < 0; k++) begin
      @(negedge clk);
      if (dbg_ack) lat = k;
    end
    chk("dbg_ack_lat", 64'(lat), 64'(elat));
    e = dq.pop_front();
    if (chkd && lat > 0) chk("dbg_r_data", 64'(dbg_r_data), 64'(e));
    @(posedge clk);
    #1;
    dbg_req = 1'b0;
    dbg_wr = 1'b0;
    dbg_addr = '0;
    dbg_w_data = '0;
  endtask

  initial begin
    int arb;
    bit gnt;
    logic [31:0] e;
    n_tests = 0;
    n_fail = 0;
    rst = 1'b0;
    cpu_req = 1'b0;
    cpu_addr = '0;
    cpu_wr = 1'b0;
    cpu_w_data = '0;
    dbg_req = 1'b0;
    dbg_addr = '0;
    dbg_wr = 1'b0;
    dbg_w_data = '0;
    cnt_en = 1'b0;
    cnt_ld = 1'b0;
    cnt_val = '0;
    cnt = '0;

    @(negedge clk);
    chk("rst_cpu_stall", 64'(cpu_stall), 64'd0);
    chk("rst_dbg_ack", 64'(dbg_ack), 64'd0);
    chk("rst_dbg_r_data", 64'(dbg_r_data), 64'd0);
    chk("rst_spr_addr", 64'(spr_addr), 64'd0);
    chk("rst_spr_wr", 64'(spr_wr), 64'd0);
    @(posedge clk);
    #1 rst = 1'b1;

    cpu_op(5'd3, 1'b1, 32'h1234_5678, 32'h0, 0, 5'd3, 1'b0);
    cpu_op(5'd3, 1'b0, 32'h0, 32'h1234_5678, 0, 5'd3, 1'b1);

    load_cnt({32'h0, 32'h10}, 1'b0);
    cpu_op(5'd1, 1'b0, 32'h0, 32'h10, 2, 5'd2, 1'b1);
    cpu_op(5'd2, 1'b0, 32'h0, 32'h0, 0, 5'd0, 1'b1);

    // Carry from 7:FFFFFFFF to 8:0 lands between H0 and H1
    load_cnt({32'h7, 32'hFFFF_FFFD}, 1'b1);
    cpu_op(5'd1, 1'b0, 32'h0, 32'h1, 4, 5'd2, 1'b1);
    cnt_en = 1'b0;
    cpu_op(5'd2, 1'b0, 32'h0, 32'h8, 0, 5'd0, 1'b1);
    cpu_op(5'd2, 1'b0, 32'h0, cnt[63:32], 0, 5'd2, 1'b1);

    cpu_op(5'd5, 1'b1, 32'h0000_AAAA, 32'h0, 0, 5'd5, 1'b0);
    cpu_op(5'd6, 1'b1, 32'hBBBB_0006, 32'h0, 0, 5'd6, 1'b0);
    dq.push_back(32'hBBBB_0006);
    @(posedge clk);
    #1;
    cpu_req = 1'b1;
    cpu_addr = 5'd5;
    dbg_req = 1'b1;
    dbg_addr = 5'd6;
    arb = 0;
    gnt = 0;
    for (int i = 0; i < 12 && !gnt; i++) begin
      @(negedge clk);
      arb++;
      if (spr_addr == 5'd6) gnt = 1;
    end
    chk("starve_grant_cycle", 64'(arb), 64'd5);
    chk("starve_cpu_stall_grant", 64'(cpu_stall), 64'd1);
    @(negedge clk);
    chk("starve_dbg_ack", 64'(dbg_ack), 64'd1);
    e = dq.pop_front();
    chk("starve_dbg_r_data", 64'(dbg_r_data), 64'(e));
    chk("starve_cpu_stall_dack", 64'(cpu_stall), 64'd1);
    @(posedge clk);
    #1 dbg_req = 1'b0;
    @(negedge clk);
    chk("starve_cpu_resume", 64'(cpu_stall), 64'd0);
    chk("starve_cpu_r_data", 64'(cpu_r_data), 64'h0000_AAAA);
    @(posedge clk);
    #1 cpu_req = 1'b0;

    dbg_op(5'd7, 1'b1, 32'h7777_0001, 32'h0, 1, 5'd7, 1'b0);
    dbg_op(5'd7, 1'b0, 32'h0, 32'h7777_0001, 1, 5'd7, 1'b1);

    load_cnt({32'h5, 32'h20}, 1'b0);
    dbg_op(5'd1, 1'b0, 32'h0, 32'h20, 3, 5'd2, 1'b1);
    dbg_op(5'd2, 1'b0, 32'h0, 32'h5, 1, 5'd0, 1'b1);
    dbg_op(5'd1, 1'b0, 32'h0, 32'h20, 3, 5'd2, 1'b1);
    dbg_op(5'd4, 1'b1, 32'hCAFE, 32'h0, 1, 5'd4, 1'b0);
    dbg_op(5'd2, 1'b0, 32'h0, 32'h5, 1, 5'd2, 1'b1);

    load_cnt({32'h0, 32'h30}, 1'b0);
    @(posedge clk);
    #1;
    dbg_req = 1'b1;
    dbg_addr = 5'd1;
    @(negedge clk);
    chk("rstseq_h0_addr", 64'(spr_addr), 64'd2);
    @(posedge clk);
    #1;
    rst = 1'b0;
    dbg_req = 1'b0;
    dbg_addr = '0;
    @(negedge clk);
    chk("rstseq_dbg_ack", 64'(dbg_ack), 64'd0);
    chk("rstseq_dbg_r_data", 64'(dbg_r_data), 64'd0);
    chk("rstseq_spr_addr", 64'(spr_addr), 64'd0);
    chk("rstseq_spr_wr", 64'(spr_wr), 64'd0);
    chk("rstseq_spr_w_data", 64'(spr_w_data), 64'd0);
    chk("rstseq_cpu_stall", 64'(cpu_stall), 64'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rstseq_no_ack", 64'(dbg_ack), 64'd0);
      chk("rstseq_idle_addr", 64'(spr_addr), 64'd0);
    end
    dbg_op(5'd1, 1'b0, 32'h0, 32'h30, 3, 5'd2, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/yutorina_spr_ctrl.md
# yutorina_spr_ctrl

Arbiter and access sequencer in front of `yutorina_spr`. It shares the single SPR port between the CPU pipeline (EX stage) and the debug unit. It also turns a read of the 64-bit cycle counter's low word into a tear-free H/L/H sequence. Sits between the pipeline/debug unit and `yutorina_spr`; drives that block's `addr`, `wr` and `w_data`, and consumes its `r_data`.

## Interface
Parameters:
- `ADDR_W`, 5: SPR address width.
- `DATA_W`, 32: word width.
- `CNT_L_ADDR`, 5'h01: address of counter low word.
- `CNT_H_ADDR`, 5'h02: address of counter high word.
- `STARVE_MAX`, 4: consecutive lost arbitrations after which debug wins (1..15).

Ports:
- `clk`  in  1: clock. One clock; all state on its rising edge.
- `rst`  in  1: reset, asynchronous, active-low.
- `cpu_req`  in  1: CPU access request, held until `cpu_stall` is low.
- `cpu_addr`  in  ADDR_W: CPU SPR address.
- `cpu_wr`  in  1: 1 = write.
- `cpu_w_data`  in  DATA_W: CPU write data.
- `cpu_r_data`  out  DATA_W: CPU read data, valid in the cycle `cpu_req & ~cpu_stall`.
- `cpu_stall`  out  1: CPU access not completing this cycle.
- `dbg_req`  in  1: debug request, held until `dbg_ack`.
- `dbg_addr`  in  ADDR_W: debug SPR address.
- `dbg_wr`  in  1: 1 = write.
- `dbg_w_data`  in  DATA_W: debug write data.
- `dbg_ack`  out  1: one-cycle completion pulse, registered.
- `dbg_r_data`  out  DATA_W: registered read data, valid with `dbg_ack`.
- `spr_addr`  out  ADDR_W: to SPR `addr`.
- `spr_wr`  out  1: to SPR `wr`.
- `spr_w_data`  out  DATA_W: to SPR `w_data`.
- `spr_r_data`  in  DATA_W: from SPR `r_data`, combinational.

## Operation
- FSM states: IDLE, RD_H0, RD_L, RD_H1, DACK. Owner register `own` (CPU/DBG) is latched on leaving IDLE.
- Arbitration happens in IDLE only; sequences are not preemptible.
  - CPU wins by default.
  - Debug wins when `cpu_req` = 0, or when `starve_cnt == STARVE_MAX`.
  - `starve_cnt` increments each IDLE cycle in which `dbg_req` = 1 and debug loses. It clears when debug is granted or `dbg_req` = 0, and saturates at STARVE_MAX.
- Plain access is any write, or any read whose address ≠ CNT_L_ADDR.
  - CPU winner: access is issued on the SPR port in the same cycle. `cpu_stall` = 0 and `cpu_r_data` = `spr_r_data`. FSM stays in IDLE.
  - Debug winner: access is issued in the same cycle. `spr_r_data` is captured into `dbg_r_data`. FSM goes to DACK, where `dbg_ack` = 1 for one cycle, then returns to IDLE.
- Counter read (read of CNT_L_ADDR) runs a fixed sequence:
  - RD_H0 reads H into `h0`.
  - RD_L reads L into `lo`.
  - RD_H1 reads H and compares it with `h0`.
  - If equal: CPU completes in RD_H1 (`cpu_r_data` = `lo`, `cpu_stall` = 0, go to IDLE). Debug gets `lo` into `dbg_r_data` and goes to DACK.
  - If not equal: `h0` ← new H and the FSM returns to RD_L.
- Shadow high word: on counter-read completion, `h0` is stored in `shadow[own]` and `shvalid[own]` is set.
  - The next read of CNT_H_ADDR by that requester returns the shadow value without touching the SPR, and clears `shvalid`.
  - Any write by that requester also clears its `shvalid`.
- `spr_wr` = 1 only in the cycle a granted write is issued. Outside granted accesses, `spr_addr`, `spr_wr` and `spr_w_data` are 0.
- `cpu_stall` = `cpu_req` & ~(CPU completing this cycle).
- Requester inputs are sampled in every sequence cycle and must stay stable while the request is held.

## Timing
- Reset (`rst` low, async): FSM = IDLE, `own` = CPU, `starve_cnt` = 0, `shvalid` = 0, `dbg_ack` = 0, `dbg_r_data` = 0, `h0`/`lo` = 0. SPR outputs are 0 and `cpu_stall` = 0.
- Reset mid-sequence abandons the sequence; no `dbg_ack` is generated.
- Latencies:
  - CPU plain access: 0 stall cycles.
  - CPU counter read: 2 stall cycles, completing in the 3rd cycle; 4 stall cycles on retry.
  - Debug plain access: `dbg_ack` 1 cycle after grant.
  - Debug counter read: `dbg_ack` 3 cycles after grant.
- Carry between H0 and H1 causes at most one retry, because the counter advances by at most 1 per cycle.
- Simultaneous `cpu_req` and `dbg_req` in IDLE: CPU wins unless starved. A CPU loser is stalled until the FSM is back in IDLE.
- `dbg_req` must drop in the cycle after `dbg_ack`; if it is still high, it is treated as a new request.

## Test plan
- Reset, CPU write of 0x1234_5678 to addr 3: `spr_wr` = 1, `spr_w_data` = 0x12345678 in the same cycle, `cpu_stall` = 0.
- CPU reads CNT_L with SPR counter H = 0, L = 0x10 → `cpu_stall` is high for 2 cycles, then `cpu_r_data` = 0x10. Next CNT_H read returns 0 with no SPR access.
- Counter at L = 0xFFFF_FFFE, H = 7 during a CPU CNT_L read → retry occurs, and the result is L = 0x0000_0000 or later with shadow H = 8. Total stall is 4 cycles.
- `cpu_req` and `dbg_req` held continuously with CPU plain reads → debug granted on the 5th arbitration cycle, `dbg_ack` 1 cycle later, CPU stalled that cycle.
- Debug CNT_L read with `rst` pulsed low in RD_L → no `dbg_ack`, all outputs 0, FSM IDLE. Re-request completes normally.
- Debug shadow valid, then debug writes addr 4 → next debug CNT_H read goes to the SPR port (`spr_addr` = 2).
